// File: rtl/bus_pkg.sv
// Shared definitions for the per-device bus transmit queues: packet width,
// broadcast address, status bundle and the sticky error flag states.
package bus_pkg;

    localparam int         PCKG_SZ   = 16;
    localparam logic [7:0] BROADCAST = 8'hFF;

    typedef struct packed {
        logic pndng;
        logic full;
        logic ovf;
        logic udf;
    } fifo_status_t;

    typedef enum logic {
        ERR_CLEAN = 1'b0,
        ERR_SET   = 1'b1
    } err_state_t;

    // Destination address lives in the top byte of every packet.
    function automatic logic [7:0] addr_of(input logic [PCKG_SZ-1:0] pkt);
        return pkt[PCKG_SZ-1 -: 8];
    endfunction

endpackage

// File: rtl/bus_dev_fifo_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module bus_dev_fifo_mem
    import bus_pkg::*;
#(
    parameter int width  = PCKG_SZ,
    parameter int depth  = 8,
    parameter int addr_w = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data
);

    logic [width-1:0] mem_r [depth];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device transmit queue between the device driver and the bus arbiter.
// Show-ahead head on D_pop; occupancy counter is the only source of full/empty.
module bus_dev_fifo
    import bus_pkg::*;
#(
    parameter int         pckg_sz   = PCKG_SZ,
    parameter int         depth     = 8,
    parameter logic [7:0] broadcast = BROADCAST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       pop,
    output logic [pckg_sz-1:0]         D_pop,
    output logic                       pndng,
    output logic                       full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       bcst_head,
    output logic                       ovf,
    output logic                       udf,
    input  logic                       clr_err
);

    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);

    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               empty_s;
    logic               full_s;
    logic               do_write_s;
    logic               do_read_s;
    logic               ovf_evt_s;
    logic               udf_evt_s;
    logic [pckg_sz-1:0] rd_data_s;
    err_state_t         ovf_state_r;
    err_state_t         ovf_next_s;
    err_state_t         udf_state_r;
    err_state_t         udf_next_s;
    fifo_status_t       status_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(depth - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == CNT_W'(depth));
    // A push into a full queue is accepted when a pop frees the head slot this edge.
    assign do_write_s = push && (!full_s || pop);
    assign do_read_s  = pop && !empty_s;
    assign ovf_evt_s  = push && full_s && !pop;
    assign udf_evt_s  = pop && empty_s;

    // Occupancy update.
    always_comb begin
        count_next_s = count_r;
        case ({do_write_s, do_read_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_read_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
        end
    end

    // Sticky error flag next-state: a fresh event beats a simultaneous clear.
    always_comb begin
        ovf_next_s = ovf_state_r;
        udf_next_s = udf_state_r;
        case (ovf_state_r)
            ERR_CLEAN: if (ovf_evt_s) ovf_next_s = ERR_SET; else ovf_next_s = ERR_CLEAN;
            ERR_SET:   if (clr_err && !ovf_evt_s) ovf_next_s = ERR_CLEAN; else ovf_next_s = ERR_SET;
            default:   ovf_next_s = ERR_CLEAN;
        endcase
        case (udf_state_r)
            ERR_CLEAN: if (udf_evt_s) udf_next_s = ERR_SET; else udf_next_s = ERR_CLEAN;
            ERR_SET:   if (clr_err && !udf_evt_s) udf_next_s = ERR_CLEAN; else udf_next_s = ERR_SET;
            default:   udf_next_s = ERR_CLEAN;
        endcase
    end

    // Sticky error flag state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_state_r <= ERR_CLEAN;
            udf_state_r <= ERR_CLEAN;
        end else begin
            ovf_state_r <= ovf_next_s;
            udf_state_r <= udf_next_s;
        end
    end

    bus_dev_fifo_mem #(
        .width (pckg_sz),
        .depth (depth),
        .addr_w(PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (do_write_s),
        .wr_addr(wr_ptr_r),
        .wr_data(D_push),
        .rd_addr(rd_ptr_r),
        .rd_data(rd_data_s)
    );

    assign status_s.pndng = !empty_s;
    assign status_s.full  = full_s;
    assign status_s.ovf   = (ovf_state_r == ERR_SET);
    assign status_s.udf   = (udf_state_r == ERR_SET);

    assign pndng     = status_s.pndng;
    assign full      = status_s.full;
    assign ovf       = status_s.ovf;
    assign udf       = status_s.udf;
    assign count     = count_r;
    assign D_pop     = status_s.pndng ? rd_data_s : {pckg_sz{1'b0}};
    assign bcst_head = status_s.pndng && (D_pop[pckg_sz-1 -: 8] == broadcast);

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Scoreboard bench for bus_dev_fifo (depth 4): directed scenarios followed by
// a random push/pop phase, all checked against a queue reference.
module tb_bus_dev_fifo;
    import bus_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        pop;
    logic [15:0] D_pop;
    logic        pndng;
    logic        full;
    logic [2:0]  count;
    logic        bcst_head;
    logic        ovf;
    logic        udf;
    logic        clr_err;

    int checks;
    int failures;

    logic [15:0] sb_q[$];
    logic        ovf_m;
    logic        udf_m;

    bus_dev_fifo #(
        .pckg_sz  (16),
        .depth    (DEPTH),
        .broadcast(8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_push   (D_push),
        .pop      (pop),
        .D_pop    (D_pop),
        .pndng    (pndng),
        .full     (full),
        .count    (count),
        .bcst_head(bcst_head),
        .ovf      (ovf),
        .udf      (udf),
        .clr_err  (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] head;
        head = (sb_q.size() > 0) ? sb_q[0] : 16'h0000;
        check_eq({tag, ":count"}, {29'd0, count}, sb_q.size());
        check_eq({tag, ":pndng"}, {31'd0, pndng}, {31'd0, (sb_q.size() > 0)});
        check_eq({tag, ":full"}, {31'd0, full}, {31'd0, (sb_q.size() == DEPTH)});
        check_eq({tag, ":D_pop"}, {16'd0, D_pop}, {16'd0, head});
        check_eq({tag, ":bcst"}, {31'd0, bcst_head},
                 {31'd0, (sb_q.size() > 0) && (addr_of(head) == BROADCAST)});
        check_eq({tag, ":ovf"}, {31'd0, ovf}, {31'd0, ovf_m});
        check_eq({tag, ":udf"}, {31'd0, udf}, {31'd0, udf_m});
    endtask

    // Called at posedge+1; applies one cycle of stimulus and checks afterwards.
    task automatic step(input string tag, input logic p, input logic [15:0] d,
                        input logic q, input logic c);
        bit was_full;
        bit was_empty;
        logic [15:0] exp_pop;
        push = p; D_push = d; pop = q; clr_err = c;
        #3;
        was_full  = (sb_q.size() == DEPTH);
        was_empty = (sb_q.size() == 0);
        if (q && !was_empty) begin
            exp_pop = sb_q.pop_front();
            check_eq({tag, ":pop_data"}, {16'd0, D_pop}, {16'd0, exp_pop});
        end
        if (p && (!was_full || q)) sb_q.push_back(d);
        if (p && was_full && !q) ovf_m = 1'b1;
        else if (c)              ovf_m = 1'b0;
        if (q && was_empty)      udf_m = 1'b1;
        else if (c)              udf_m = 1'b0;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        checks = 0; failures = 0;
        ovf_m = 1'b0; udf_m = 1'b0;
        reset = 1'b0; push = 1'b0; D_push = 16'h0000; pop = 1'b0; clr_err = 1'b0;
        #2;
        check_outputs("reset");
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        step("fill0", 1'b1, 16'h0111, 1'b0, 1'b0);
        step("fill1", 1'b1, 16'h0222, 1'b0, 1'b0);
        step("fill2", 1'b1, 16'h0333, 1'b0, 1'b0);
        step("fill3", 1'b1, 16'h0444, 1'b0, 1'b0);
        check_eq("fill_full", {31'd0, full}, 32'd1);
        check_eq("fill_count", {29'd0, count}, 32'd4);

        step("ovf", 1'b1, 16'h0555, 1'b0, 1'b0);
        check_eq("ovf_flag", {31'd0, ovf}, 32'd1);
        check_eq("ovf_head", {16'd0, D_pop}, 32'h0111);
        step("ovf_clr", 1'b0, 16'h0000, 1'b0, 1'b1);

        step("fullpp", 1'b1, 16'h0AAA, 1'b1, 1'b0);
        check_eq("fullpp_count", {29'd0, count}, 32'd4);
        check_eq("fullpp_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("wrap_head", {16'd0, D_pop}, 32'h0AAA);
        step("drain_last", 1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("empty_dpop", {16'd0, D_pop}, 32'h0000);

        step("emptypp", 1'b1, 16'h0123, 1'b1, 1'b0);
        check_eq("emptypp_udf", {31'd0, udf}, 32'd1);
        check_eq("emptypp_head", {16'd0, D_pop}, 32'h0123);
        step("udf_clr", 1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("udf_cleared", {31'd0, udf}, 32'd0);
        step("pop_last", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("clr_vs_evt", 1'b0, 16'h0000, 1'b1, 1'b1);
        check_eq("clr_vs_evt_udf", {31'd0, udf}, 32'd1);
        step("udf_clr2", 1'b0, 16'h0000, 1'b0, 1'b1);

        step("bcst_push", 1'b1, 16'hFF42, 1'b0, 1'b0);
        check_eq("bcst_set", {31'd0, bcst_head}, 32'd1);
        step("bcst_push2", 1'b1, 16'h0242, 1'b0, 1'b0);
        step("bcst_pop", 1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("bcst_clear", {31'd0, bcst_head}, 32'd0);
        step("bcst_pop2", 1'b0, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] rd;
            rd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rd[15:8] = 8'hFF;
            step("rand", 1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end

        while (sb_q.size() > 0) step("pre_rst_drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("pre_rst_clr", 1'b0, 16'h0000, 1'b0, 1'b1);
        step("rst_q0", 1'b1, 16'h0A01, 1'b0, 1'b0);
        step("rst_q1", 1'b1, 16'h0A02, 1'b0, 1'b0);
        step("rst_q2", 1'b1, 16'h0A03, 1'b0, 1'b0);
        #4;
        reset = 1'b0;
        sb_q.delete();
        ovf_m = 1'b0; udf_m = 1'b0;
        #1;
        check_eq("arst_count", {29'd0, count}, 32'd0);
        check_eq("arst_pndng", {31'd0, pndng}, 32'd0);
        check_eq("arst_dpop", {16'd0, D_pop}, 32'h0000);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst");
        step("post_rst_push", 1'b1, 16'h0777, 1'b0, 1'b0);
        check_eq("post_rst_head", {16'd0, D_pop}, 32'h0777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
